// File: rtl/systolic_feeder.sv
// systolic_feeder: skews A/B beats into systolic_array and sequences shift/acc control; define SYSTOLIC_FEEDER_ACC_CLEAR_EN for a per-job acc_rst CLEAR state
module systolic_feeder #(
  parameter int MATRIX_SIZE = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int K_MAX       = 256
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [$clog2(K_MAX+1)-1:0]        k_len,
  input  logic                              vec_valid,
  output logic                              vec_ready,
  input  logic [DATA_WIDTH*MATRIX_SIZE-1:0] a_vec,
  input  logic [DATA_WIDTH*MATRIX_SIZE-1:0] b_vec,
  output logic [DATA_WIDTH*MATRIX_SIZE-1:0] in_left_flat,
  output logic [DATA_WIDTH*MATRIX_SIZE-1:0] in_top_flat,
  output logic                              shift_en,
  output logic                              acc_en,
  output logic                              acc_rst,
  output logic                              busy,
  output logic                              done
);
  localparam int KW  = $clog2(K_MAX+1);
  localparam int DCW = $clog2(2*MATRIX_SIZE+1);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
  state_t state, state_d;
  logic [KW-1:0] k_lat, beat_cnt;
  logic [DCW-1:0] drain_cnt;
  logic accept, last_beat, adv, shift_q;
  assign accept    = vec_valid && state == FEED;
  assign last_beat = accept && beat_cnt == k_lat - 1'b1;
  assign adv       = accept || state == DRAIN;
  assign vec_ready = state == FEED;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign shift_en  = shift_q;
  assign acc_en    = shift_q;
`ifdef SYSTOLIC_FEEDER_ACC_CLEAR_EN
  assign acc_rst = state == CLEAR;
`else
  assign acc_rst = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
`ifdef SYSTOLIC_FEEDER_ACC_CLEAR_EN
      IDLE:  if (start) state_d = CLEAR;
`else
      IDLE:  if (start) state_d = k_len == '0 ? DONE : FEED;
`endif
      CLEAR: state_d = k_lat == '0 ? DONE : FEED;
      FEED:  if (last_beat) state_d = DRAIN;
      DRAIN: if (drain_cnt == DCW'(2*MATRIX_SIZE-1)) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      k_lat     <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      shift_q   <= 1'b0;
    end else begin
      shift_q   <= adv;
      drain_cnt <= state == DRAIN ? drain_cnt + 1'b1 : '0;
      if (state == IDLE && start) begin
        k_lat    <= k_len > KW'(K_MAX) ? KW'(K_MAX) : k_len;
        beat_cnt <= '0;
      end else if (accept) beat_cnt <= beat_cnt + 1'b1;
    end
  for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] a_sr [i+1];
    logic [DATA_WIDTH-1:0] b_sr [i+1];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        for (int s = 0; s <= i; s++) begin
          a_sr[s] <= '0;
          b_sr[s] <= '0;
        end
      end else if (adv) begin
        a_sr[0] <= state == FEED ? a_vec[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        b_sr[0] <= state == FEED ? b_vec[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int s = 1; s <= i; s++) begin
          a_sr[s] <= a_sr[s-1];
          b_sr[s] <= b_sr[s-1];
        end
      end
    assign in_left_flat[i*DATA_WIDTH +: DATA_WIDTH] = a_sr[i];
    assign in_top_flat[i*DATA_WIDTH +: DATA_WIDTH]  = b_sr[i];
  end
endmodule
